// File: rtl/puf_measure_ctrl_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement controller:
// FSM state encodings, RO array geometry and counter sizing.
package puf_measure_ctrl_pkg;

    localparam int RO_COUNT = 32;
    localparam int RO_HALF  = RO_COUNT / 2;
    localparam int CHAL_W   = 8;
    localparam int SEL_W    = 8;
    // Wide enough for any legal TIMEOUT_CYCLES (up to 17 bits).
    localparam int CNT_W    = 17;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CLEAR   = 3'd2,
        ST_MEASURE = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    function automatic int idx_width(input int n_bits);
        return (n_bits > 1) ? $clog2(n_bits) : 1;
    endfunction

endpackage

// File: rtl/puf_measure_ctrl_if.sv
// Host-side request/response bundle of the PUF measurement controller.
interface puf_measure_ctrl_if #(
    parameter int N_BITS = 8
) ();
    import puf_measure_ctrl_pkg::*;

    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic              busy;
    logic [N_BITS-1:0] response;
    logic              resp_valid;
    logic              resp_ready;
    logic              timeout_err;

    modport master (
        output start,
        output challenge,
        output resp_ready,
        input  busy,
        input  response,
        input  resp_valid,
        input  timeout_err
    );

    modport slave (
        input  start,
        input  challenge,
        input  resp_ready,
        output busy,
        output response,
        output resp_valid,
        output timeout_err
    );

endinterface

// File: rtl/puf_measure_ctrl_sync_nff.sv
// N-stage flip-flop synchronizer for asynchronous arbiter outputs, clears to 0.
module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d[0] = d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            assign sync_d[gi] = sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/puf_measure_ctrl.sv
// Sequences challenge load, per-bit RO race measurement and response handoff
// for the serial ring-oscillator PUF datapath.
module puf_measure_ctrl
    import puf_measure_ctrl_pkg::*;
#(
    parameter int N_BITS         = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                clock,
    input  logic                reset,
    puf_measure_ctrl_if.slave   host,
    input  logic [SEL_W-1:0]    sel,
    input  logic                bit_done,
    input  logic                bit_in,
    output logic                scr_load,
    output logic                scr_step,
    output logic [CHAL_W-1:0]   scr_seed,
    output logic                cnt_reset,
    output logic                arb_reset,
    output logic [RO_COUNT-1:0] ro_enable
);

    localparam int IDX_W = idx_width(N_BITS);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_IGNORE  = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_BITS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [N_BITS-1:0]  response_q, response_d;
    logic               timeout_q, timeout_d;
    logic               bit_q, bit_d;
    logic [CHAL_W-1:0]  challenge_q, challenge_d;

    logic               done_sync;
    logic               win_sync;
    logic               ro_run;
    logic [RO_HALF-1:0] ro_lo;
    logic [RO_HALF-1:0] ro_hi;

    sync_nff #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clock (clock),
        .reset (reset),
        .d     (bit_done),
        .q     (done_sync)
    );

    sync_nff #(.STAGES(SYNC_STAGES)) u_sync_win (
        .clock (clock),
        .reset (reset),
        .d     (bit_in),
        .q     (win_sync)
    );

    // One enable per half of the array, picked directly by the scrambler nibbles.
    generate
        for (genvar gi = 0; gi < RO_HALF; gi++) begin : g_ro
            assign ro_lo[gi] = (sel[3:0] == 4'(gi));
            assign ro_hi[gi] = (sel[7:4] == 4'(gi));
        end
    endgenerate

    assign ro_enable        = ro_run ? {ro_hi, ro_lo} : '0;
    assign scr_seed         = challenge_q;
    assign host.response    = response_q;
    assign host.timeout_err = timeout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            response_q  <= '0;
            timeout_q   <= 1'b0;
            bit_q       <= 1'b0;
            challenge_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            response_q  <= response_d;
            timeout_q   <= timeout_d;
            bit_q       <= bit_d;
            challenge_q <= challenge_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        response_d      = response_q;
        timeout_d       = timeout_q;
        bit_d           = bit_q;
        challenge_d     = challenge_q;
        scr_load        = 1'b0;
        scr_step        = 1'b0;
        cnt_reset       = 1'b1;
        arb_reset       = 1'b1;
        ro_run          = 1'b0;
        host.busy       = 1'b1;
        host.resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                host.busy = 1'b0;
                if (host.start) begin
                    challenge_d = host.challenge;
                    response_d  = '0;
                    timeout_d   = 1'b0;
                    bit_idx_d   = '0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                scr_load = 1'b1;
                cnt_d    = '0;
                state_d  = ST_CLEAR;
            end

            ST_CLEAR: begin
                ro_run = 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_MEASURE: begin
                cnt_reset = 1'b0;
                arb_reset = 1'b0;
                ro_run    = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The first SYNC_STAGES samples still carry pre-race history.
                if ((cnt_q >= SYNC_IGNORE) && done_sync) begin
                    bit_d   = win_sync;
                    state_d = ST_CAPTURE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    bit_d     = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                response_d[bit_idx_q] = bit_q;
                state_d               = ST_NEXT;
            end

            ST_NEXT: begin
                if (bit_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    scr_step  = 1'b1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_CLEAR;
                end
            end

            ST_DONE: begin
                host.resp_valid = 1'b1;
                if (host.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Directed bench for puf_measure_ctrl with a behavioural arbiter/scrambler model.
module tb_puf_measure_ctrl;

    localparam int N_BITS   = 8;
    localparam int SETTLE   = 4;
    localparam int TIMEOUT  = 20;
    localparam int SYNC     = 2;
    localparam int DELAY    = 10;
    // Done raised on the DELAY-th MEASURE negedge, seen SYNC cycles later.
    localparam int M_NORM   = DELAY + SYNC;
    localparam int PER_BIT  = SETTLE + M_NORM + 2;
    localparam int LAT_NORM = 1 + N_BITS * PER_BIT;
    localparam int LAT_TO   = LAT_NORM + (TIMEOUT - M_NORM);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sel = 8'h3C;
    logic        bit_done = 1'b0;
    logic        bit_in = 1'b0;
    logic        scr_load, scr_step, cnt_reset, arb_reset;
    logic [31:0] ro_enable;
    logic [7:0]  scr_seed;

    puf_measure_ctrl_if #(.N_BITS(N_BITS)) host_if ();

    puf_measure_ctrl #(
        .N_BITS         (N_BITS),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .host      (host_if.slave),
        .sel       (sel),
        .bit_done  (bit_done),
        .bit_in    (bit_in),
        .scr_load  (scr_load),
        .scr_step  (scr_step),
        .scr_seed  (scr_seed),
        .cnt_reset (cnt_reset),
        .arb_reset (arb_reset),
        .ro_enable (ro_enable)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          tb_bit = 0;
    int          meas_cyc = 0;
    int          meas_len = 0;
    int          meas_hist [N_BITS];
    int          load_cnt = 0;
    int          step_cnt = 0;
    int          ro_on = 0;
    int          ro_wrong = 0;
    int          never_bit = -1;
    logic        stale_mode = 1'b0;
    logic [7:0]  pattern = 8'h55;
    logic [31:0] exp_ro = 32'h0008_1000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor plus arbiter model; drives the asynchronous inputs away from posedge.
    always @(negedge clock) begin
        if (reset) begin
            tb_bit   = 0;
            meas_cyc = 0;
            meas_len = 0;
            bit_done = 1'b0;
            bit_in   = 1'b0;
        end else begin
            if (!cnt_reset) begin
                meas_len++;
            end else if (meas_len != 0) begin
                if (tb_bit < N_BITS) meas_hist[tb_bit] = meas_len;
                meas_len = 0;
            end
            if (scr_load) begin
                tb_bit = 0;
                load_cnt++;
            end
            if (scr_step) begin
                tb_bit++;
                step_cnt++;
            end
            if (ro_enable != 32'h0) begin
                ro_on++;
                if (ro_enable != exp_ro) ro_wrong++;
            end
            if (arb_reset) begin
                meas_cyc = 0;
                bit_done = stale_mode;
                bit_in   = stale_mode ? ~pattern[tb_bit % N_BITS] : 1'b0;
            end else begin
                meas_cyc++;
                if (meas_cyc >= DELAY && tb_bit != never_bit) begin
                    bit_done = 1'b1;
                    bit_in   = pattern[tb_bit % N_BITS];
                end else begin
                    bit_done = 1'b0;
                    bit_in   = 1'b0;
                end
            end
        end
    end

    task automatic clear_stats();
        load_cnt = 0;
        step_cnt = 0;
        ro_on    = 0;
        ro_wrong = 0;
        for (int i = 0; i < N_BITS; i++) meas_hist[i] = 0;
    endtask

    // Returns at the negedge after start is sampled (DUT now in LOAD).
    task automatic start_run(input logic [7:0] chal);
        @(negedge clock);
        host_if.start     = 1'b1;
        host_if.challenge = chal;
        @(negedge clock);
        host_if.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!host_if.resp_valid && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        check_eq({tag, "_valid_seen"}, 32'(host_if.resp_valid), 32'd1);
        $display("resp %s response=0x%02h timeout_err=%0d latency=%0d",
                 tag, host_if.response, host_if.timeout_err, lat);
    endtask

    task automatic handshake(input string tag);
        host_if.resp_ready = 1'b1;
        @(negedge clock);
        host_if.resp_ready = 1'b0;
        check_eq({tag, "_idle_after_ready"}, 32'(host_if.busy), 32'd0);
        check_eq({tag, "_valid_drop"}, 32'(host_if.resp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        host_if.start      = 1'b0;
        host_if.challenge  = 8'h00;
        host_if.resp_ready = 1'b0;
        repeat (3) @(negedge clock);

        check_eq("rst_busy", 32'(host_if.busy), 32'd0);
        check_eq("rst_response", 32'(host_if.response), 32'd0);
        check_eq("rst_valid", 32'(host_if.resp_valid), 32'd0);
        check_eq("rst_timeout", 32'(host_if.timeout_err), 32'd0);
        check_eq("rst_pulses", {30'd0, scr_load, scr_step}, 32'd0);
        check_eq("rst_ro", ro_enable, 32'd0);
        check_eq("rst_resets", {30'd0, cnt_reset, arb_reset}, 32'd3);
        reset = 1'b0;

        // Nominal run: constant sel, alternating winners.
        clear_stats();
        start_run(8'hA5);
        check_eq("busy_after_start", 32'(host_if.busy), 32'd1);
        wait_valid("nominal", lat);
        check_eq("nom_latency", 32'(lat), 32'(LAT_NORM));
        check_eq("nom_seed", 32'(scr_seed), 32'hA5);
        check_eq("nom_response", 32'(host_if.response), 32'h55);
        check_eq("nom_timeout", 32'(host_if.timeout_err), 32'd0);
        check_eq("nom_load_pulses", 32'(load_cnt), 32'd1);
        check_eq("nom_step_pulses", 32'(step_cnt), 32'd7);
        check_eq("nom_ro_cycles", 32'(ro_on), 32'(N_BITS * (SETTLE + M_NORM)));
        check_eq("nom_ro_wrong", 32'(ro_wrong), 32'd0);
        for (int i = 0; i < N_BITS; i++) check_eq("nom_meas_len", 32'(meas_hist[i]), 32'(M_NORM));

        // Consumer stalls in DONE; start must be ignored.
        for (int c = 0; c < 50; c++) begin
            host_if.start     = (c % 7 == 3);
            host_if.challenge = 8'h3C;
            @(negedge clock);
            check_eq("hold_valid", 32'(host_if.resp_valid), 32'd1);
            check_eq("hold_response", 32'(host_if.response), 32'h55);
            check_eq("hold_timeout", 32'(host_if.timeout_err), 32'd0);
        end
        host_if.start = 1'b0;
        handshake("hold");
        @(negedge clock);
        check_eq("hold_stays_idle", 32'(host_if.busy), 32'd0);

        // Bit 2 never resolves: forced 0 after the full timeout window.
        clear_stats();
        never_bit = 2;
        start_run(8'h5A);
        wait_valid("timeout", lat);
        check_eq("to_latency", 32'(lat), 32'(LAT_TO));
        check_eq("to_response", 32'(host_if.response), 32'h51);
        check_eq("to_timeout_err", 32'(host_if.timeout_err), 32'd1);
        check_eq("to_meas_len_bit2", 32'(meas_hist[2]), 32'(TIMEOUT));
        check_eq("to_meas_len_bit3", 32'(meas_hist[3]), 32'(M_NORM));
        handshake("timeout");
        never_bit = -1;

        // Stale done/winner held high while the arbiter is in reset.
        clear_stats();
        stale_mode = 1'b1;
        pattern    = 8'h96;
        start_run(8'h11);
        wait_valid("stale", lat);
        check_eq("stale_response", 32'(host_if.response), 32'h96);
        check_eq("stale_timeout", 32'(host_if.timeout_err), 32'd0);
        check_eq("stale_latency", 32'(lat), 32'(LAT_NORM));
        check_eq("stale_meas_len0", 32'(meas_hist[0]), 32'(M_NORM));
        check_eq("stale_meas_len5", 32'(meas_hist[5]), 32'(M_NORM));
        handshake("stale");
        stale_mode = 1'b0;

        // Back-to-back with resp_ready tied high.
        host_if.resp_ready = 1'b1;
        pattern = 8'hFF;
        start_run(8'h00);
        wait_valid("b2b_first", lat);
        check_eq("b2b_first_response", 32'(host_if.response), 32'hFF);
        pattern = 8'h00;
        @(negedge clock);
        check_eq("b2b_first_pulse", 32'(host_if.resp_valid), 32'd0);
        host_if.start     = 1'b1;
        host_if.challenge = 8'hFF;
        @(negedge clock);
        host_if.start = 1'b0;
        check_eq("b2b_second_busy", 32'(host_if.busy), 32'd1);
        wait_valid("b2b_second", lat);
        check_eq("b2b_second_response", 32'(host_if.response), 32'h00);
        check_eq("b2b_second_latency", 32'(lat), 32'(LAT_NORM));
        check_eq("b2b_second_seed", 32'(scr_seed), 32'hFF);
        @(negedge clock);
        check_eq("b2b_second_pulse", 32'(host_if.resp_valid), 32'd0);
        host_if.resp_ready = 1'b0;

        // Reset while measuring bit 3.
        pattern = 8'h55;
        start_run(8'hC3);
        lat = 0;
        while (!(tb_bit == 3 && !cnt_reset) && lat < 1000) begin
            @(negedge clock);
            lat++;
        end
        check_eq("mid_reached_bit3", 32'(tb_bit), 32'd3);
        check_eq("mid_partial_response", 32'(host_if.response), 32'h05);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_busy", 32'(host_if.busy), 32'd0);
        check_eq("mid_response", 32'(host_if.response), 32'd0);
        check_eq("mid_ro", ro_enable, 32'd0);
        check_eq("mid_resets", {30'd0, cnt_reset, arb_reset}, 32'd3);
        check_eq("mid_valid", 32'(host_if.resp_valid), 32'd0);
        @(negedge clock);
        check_eq("mid_stays_idle", 32'(host_if.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
